// File: rtl/sr_controller.sv
// sr_controller: sequencer and arbiter for the Sayeh carry/zero status register.
// Turns each granted flag-update request (ALU, flag instruction, interrupt save,
// interrupt restore) into exactly one registered strobe cycle on the status register.
// Optional feature macro: SR_CTRL_SHADOW_EN enables the DEPTH-entry flag shadow
// stack and stk_err. Without it, save/restore are still acked with the same timing,
// but they store nothing and drive no strobe.
module sr_controller #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       alu_req,
   input  logic       alu_c,
   input  logic       alu_z,
   output logic       alu_ack,
   input  logic       op_req,
   input  logic [1:0] op_code,
   output logic       op_ack,
   input  logic       save_req,
   output logic       save_ack,
   input  logic       rest_req,
   output logic       rest_ack,
   input  logic       sr_c,
   input  logic       sr_z,
   output logic       sr_load,
   output logic       sr_cset,
   output logic       sr_creset,
   output logic       sr_zset,
   output logic       sr_zreset,
   output logic       sr_cin,
   output logic       sr_zin,
   output logic       stk_err
);

   typedef enum logic [2:0] {
      IDLE, ALU_SETTLE, ALU_LOAD, STROBE, SAVE, RESTORE, GAP
   } state_t;

   state_t     state, state_nx;
   logic       load_nx, cin_nx, zin_nx;
   logic       cset_nx, creset_nx, zset_nx, zreset_nx;
   logic       alu_ack_nx, op_ack_nx, save_ack_nx, rest_ack_nx;
   logic       push, pop, err_set;
   logic       stk_full, stk_empty;
   logic [1:0] stk_top;

   // Next state plus next output values. Outputs are computed one state early
   // and registered, so they are high exactly while the FSM sits in the action state.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_nx    = state;
      load_nx     = 1'b0;
      cin_nx      = 1'b0;
      zin_nx      = 1'b0;
      cset_nx     = 1'b0;
      creset_nx   = 1'b0;
      zset_nx     = 1'b0;
      zreset_nx   = 1'b0;
      alu_ack_nx  = 1'b0;
      op_ack_nx   = 1'b0;
      save_ack_nx = 1'b0;
      rest_ack_nx = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      err_set     = 1'b0;
      case (state)
         IDLE: begin
            // Fixed priority: restore > save > alu > op.
            if (rest_req) begin
               state_nx    = RESTORE;
               rest_ack_nx = 1'b1;
               if (stk_empty) begin
                  err_set = 1'b1;
               end else begin
                  pop     = 1'b1;
                  load_nx = 1'b1;
                  cin_nx  = stk_top[1];
                  zin_nx  = stk_top[0];
               end
            end else if (save_req) begin
               state_nx    = SAVE;
               save_ack_nx = 1'b1;
               if (stk_full) err_set = 1'b1;
               else          push    = 1'b1;
            end else if (alu_req) begin
               state_nx = ALU_SETTLE;
            end else if (op_req) begin
               state_nx  = STROBE;
               op_ack_nx = 1'b1;
               unique case (op_code)
                  2'd0: cset_nx   = 1'b1;
                  2'd1: creset_nx = 1'b1;
                  2'd2: zset_nx   = 1'b1;
                  2'd3: zreset_nx = 1'b1;
               endcase
            end
         end
         ALU_SETTLE: begin
            // ALU flags have had a full cycle to settle; capture them on this edge.
            state_nx   = ALU_LOAD;
            load_nx    = 1'b1;
            cin_nx     = alu_c;
            zin_nx     = alu_z;
            alu_ack_nx = 1'b1;
         end
         ALU_LOAD, STROBE, SAVE, RESTORE: state_nx = GAP;
         GAP:                             state_nx = IDLE;
         default:                         state_nx = IDLE;
      endcase
   end

   // State and output registers; reset aborts any transaction with nothing emitted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sr_load   <= 1'b0;
         sr_cin    <= 1'b0;
         sr_zin    <= 1'b0;
         sr_cset   <= 1'b0;
         sr_creset <= 1'b0;
         sr_zset   <= 1'b0;
         sr_zreset <= 1'b0;
         alu_ack   <= 1'b0;
         op_ack    <= 1'b0;
         save_ack  <= 1'b0;
         rest_ack  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state     <= state_nx;
         sr_load   <= load_nx;
         sr_cin    <= cin_nx;
         sr_zin    <= zin_nx;
         sr_cset   <= cset_nx;
         sr_creset <= creset_nx;
         sr_zset   <= zset_nx;
         sr_zreset <= zreset_nx;
         alu_ack   <= alu_ack_nx;
         op_ack    <= op_ack_nx;
         save_ack  <= save_ack_nx;
         rest_ack  <= rest_ack_nx;
      end
   end

`ifdef SR_CTRL_SHADOW_EN
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0]    stack [DEPTH];
   logic [CW-1:0] count;
   logic [CW-1:0] top_idx;

   assign top_idx   = count - CW'(1);
   assign stk_full  = (count == CW'(DEPTH));
   assign stk_empty = (count == '0);
   assign stk_top   = stack[top_idx[IW-1:0]];

   // Shadow stack storage, written on a push with the live status-register flags.
   // NOTE: the storage array has no reset; the entry count alone defines what is valid.
   always_ff @(posedge clk) begin
      if (push) stack[count[IW-1:0]] <= {sr_c, sr_z};
   end

   // Entry count and sticky error flag; only rst clears stk_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         stk_err <= 1'b0;
      end else begin
         if (push)     count <= count + CW'(1);
         else if (pop) count <= count - CW'(1);
         if (err_set)  stk_err <= 1'b1;
      end
   end
`else
   // No storage: restore always sees an empty stack, which suppresses its strobe.
   logic unused_shadow;
   assign stk_full      = 1'b0;
   assign stk_empty     = 1'b1;
   assign stk_top       = 2'b00;
   assign stk_err       = 1'b0;
   assign unused_shadow = ^{sr_c, sr_z, push, pop, err_set, DEPTH[0]};
`endif

endmodule

// File: tb/tb_sr_controller.sv
// Self-checking bench for sr_controller: randomized transactions checked against a
// transaction-level model (request set -> ack order, ack cycle, strobe vector, stack).
module tb_sr_controller;

   localparam int DEPTH = 4;
`ifdef SR_CTRL_SHADOW_EN
   localparam bit SHADOW = 1'b1;
`else
   localparam bit SHADOW = 1'b0;
`endif
   localparam int K_OP = 0, K_ALU = 1, K_SAVE = 2, K_REST = 3;

   logic clk = 1'b0, rst = 1'b1;
   logic alu_req = 0, alu_c = 0, alu_z = 0, alu_ack;
   logic op_req = 0, op_ack;
   logic [1:0] op_code = '0;
   logic save_req = 0, save_ack, rest_req = 0, rest_ack;
   logic sr_c = 0, sr_z = 0;
   logic sr_load, sr_cset, sr_creset, sr_zset, sr_zreset, sr_cin, sr_zin, stk_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: shadow stack contents and sticky error.
   logic [1:0] m_stack[$];
   logic       m_err = 1'b0;

   // [10]=load [9]=cin [8]=zin [7]=cset [6]=creset [5]=zset [4]=zreset
   // [3]=rest_ack [2]=save_ack [1]=alu_ack [0]=op_ack (ack bit index == kind)
   logic [10:0] obs;
   assign obs = {sr_load, sr_cin, sr_zin, sr_cset, sr_creset, sr_zset, sr_zreset,
                 rest_ack, save_ack, alu_ack, op_ack};

   sr_controller #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_req(alu_req), .alu_c(alu_c), .alu_z(alu_z), .alu_ack(alu_ack),
      .op_req(op_req), .op_code(op_code), .op_ack(op_ack),
      .save_req(save_req), .save_ack(save_ack),
      .rest_req(rest_req), .rest_ack(rest_ack),
      .sr_c(sr_c), .sr_z(sr_z),
      .sr_load(sr_load), .sr_cset(sr_cset), .sr_creset(sr_creset),
      .sr_zset(sr_zset), .sr_zreset(sr_zreset),
      .sr_cin(sr_cin), .sr_zin(sr_zin), .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   // Global rules: at most one SR control line per cycle; data is 0 unless loading.
   always @(negedge clk) begin
      if (!rst) begin
         n_checks++;
         if ($countones({obs[10], obs[7:4]}) > 1 || (!obs[10] && obs[9:8] != 2'b00)) begin
            n_fail++;
            $display("FAIL strobe_rules: got %b required one-hot controls and zero data when no load", obs[10:4]);
         end
      end
   end

   // Expected strobe/ack vector of one transaction, updating the model stack.
   function automatic logic [10:0] model_txn(input int kind, input logic ac, input logic az,
                                             input logic [1:0] code, input logic sc, input logic sz);
      logic [10:0] v;
      logic [1:0]  e;
      v = '0;
      v[kind] = 1'b1;
      case (kind)
         K_OP:  v[7 - int'(code)] = 1'b1;
         K_ALU: v[10:8] = {1'b1, ac, az};
         K_SAVE: if (SHADOW) begin
            if (m_stack.size() == DEPTH) m_err = 1'b1;
            else m_stack.push_back({sc, sz});
         end
         K_REST: if (SHADOW) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else begin
               e = m_stack.pop_back();
               v[10:8] = {1'b1, e};
            end
         end
         default: ;
      endcase
      return v;
   endfunction

   task automatic set_req(input int k, input logic v);
      case (k)
         K_OP:   op_req   = v;
         K_ALU:  alu_req  = v;
         K_SAVE: save_req = v;
         default: rest_req = v;
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b1;
      alu_req = 0; op_req = 0; save_req = 0; rest_req = 0;
      #1;
      n_checks++;
      if (obs !== '0 || stk_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got obs=%b stk_err=%b required all zero", obs, stk_err);
      end
      m_stack.delete();
      m_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Raise a set of requests together at a negedge; each requester drops on its ack.
   // Expected ack cycles follow from priority order, latency (1 or 2 for ALU) and
   // occupancy (3 cycles, 4 for ALU).
   task automatic run_multi(input logic [3:0] mask, input logic ac, input logic az,
                            input logic [1:0] code, input logic sc, input logic sz);
      int          exp_cyc[4], got_cyc[4], n_ack[4];
      logic [10:0] exp_vec[4], got_vec[4];
      int          t;
      logic [3:0]  pending;
      t = 0;
      for (int k = 3; k >= 0; k--) begin
         exp_cyc[k] = -1; got_cyc[k] = -1; n_ack[k] = 0;
         exp_vec[k] = '0; got_vec[k] = '0;
         if (mask[k]) begin
            exp_vec[k] = model_txn(k, ac, az, code, sc, sz);
            exp_cyc[k] = t + ((k == K_ALU) ? 2 : 1);
            t += (k == K_ALU) ? 4 : 3;
         end
      end
      alu_c = ac; alu_z = az; op_code = code; sr_c = sc; sr_z = sz;
      for (int k = 0; k < 4; k++) set_req(k, mask[k]);
      pending = mask;
      for (int cyc = 1; cyc <= 24 && pending != 0; cyc++) begin
         @(negedge clk);
         if (obs[3:0] == 4'b0000) begin
            n_checks++;
            if (obs !== '0) begin
               n_fail++;
               $display("FAIL quiet_without_ack: cycle %0d got %b required 0", cyc, obs);
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (obs[k]) begin
               n_ack[k]++;
               if (got_cyc[k] < 0) begin
                  got_cyc[k] = cyc;
                  got_vec[k] = obs;
               end
               pending[k] = 1'b0;
               set_req(k, 1'b0);
            end
         end
      end
      if (pending != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL ack_timeout: pending %b required 0000", pending);
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (n_ack[k] != int'(mask[k])) begin
            n_fail++;
            $display("FAIL ack_count kind%0d: got %0d required %0d", k, n_ack[k], int'(mask[k]));
         end
         if (mask[k]) begin
            n_checks++;
            if (got_cyc[k] != exp_cyc[k]) begin
               n_fail++;
               $display("FAIL ack_cycle kind%0d: got %0d required %0d", k, got_cyc[k], exp_cyc[k]);
            end
            n_checks++;
            if (got_vec[k] !== exp_vec[k]) begin
               n_fail++;
               $display("FAIL strobe_vec kind%0d: got %b required %b", k, got_vec[k], exp_vec[k]);
            end
         end
      end
      for (int g = 0; g < 2; g++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== '0) begin
            n_fail++;
            $display("FAIL gap_quiet: got %b required 0", obs);
         end
      end
      n_checks++;
      if (stk_err !== m_err) begin
         n_fail++;
         $display("FAIL stk_err: got %b required %b", stk_err, m_err);
      end
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_op_pair();
      run_multi(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      run_multi(4'b0001, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
   endtask

   task automatic test_alu();
      run_multi(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      run_multi(4'b0010, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
   endtask

   task automatic test_priority();
      run_multi(4'b0111, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
      run_multi(4'b1100, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      run_multi(4'b1111, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1);
   endtask

   task automatic test_shadow_stack();
      do_reset();
      run_multi(4'b0100, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
      run_multi(4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      run_multi(4'b1000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
      run_multi(4'b1000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic test_stack_errors();
      do_reset();
      for (int i = 0; i < 5; i++)
         run_multi(4'b0100, 1'b0, 1'b0, 2'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_reset();
      run_multi(4'b1000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid_strobe();
      op_code = 2'd1;
      op_req  = 1'b1;
      @(negedge clk);
      n_checks++;
      if (obs !== 11'b000_0100_0001) begin
         n_fail++;
         $display("FAIL pre_reset_strobe: got %b required 00001000001", obs);
      end
      #2;
      rst    = 1'b1;
      op_req = 1'b0;
      #1;
      n_checks++;
      if (obs !== '0 || stk_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_strobe: got obs=%b stk_err=%b required all zero", obs, stk_err);
      end
      m_stack.delete();
      m_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL post_reset_quiet: got %b required 0", obs);
      end
      run_multi(4'b0001, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         if (i % 20 == 19) do_reset();
         run_multi(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_op_pair();
      test_alu();
      test_priority();
      test_shadow_stack();
      test_stack_errors();
      test_reset_mid_strobe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sr_controller.md
# sr_controller

Sequencer and arbiter for the Sayeh carry/zero status register. It accepts flag-update requests from four sources and turns each granted request into exactly one well-formed strobe cycle on the status register's SRload/Cset/Creset/Zset/Zreset/Cin/Zin inputs:
- ALU result flags
- explicit flag instructions (set/clear C or Z)
- interrupt entry (save flags)
- return-from-interrupt (restore flags)

It sits between the control unit and the status register and never asserts more than one status-register control line per cycle.

## Interface
- DEPTH, 4, number of entries in the flag shadow stack (2..16)
- clk  in  1  rising-edge clock, shared with the status register
- rst  in  1  asynchronous, active-high reset
- alu_req  in  1  ALU flag update request; held until alu_ack
- alu_c, alu_z  in  1 each  ALU carry/zero; must be stable from req until ack
- alu_ack  out  1  one-cycle pulse, coincides with the SRload cycle
- op_req  in  1  flag-instruction request; held until op_ack
- op_code  in  2  0=CSET, 1=CCLR, 2=ZSET, 3=ZCLR; stable while op_req
- op_ack  out  1  one-cycle pulse, coincides with the strobe cycle
- save_req / save_ack  in / out  1  interrupt-entry flag push
- rest_req / rest_ack  in / out  1  return-from-interrupt flag pop
- sr_c, sr_z  in  1 each  current Cout/Zout fed back from the status register
- sr_load, sr_cset, sr_creset, sr_zset, sr_zreset  out  1 each  status register strobes
- sr_cin, sr_zin  out  1 each  data to the status register Cin/Zin
- stk_err  out  1  sticky: shadow-stack overflow or underflow occurred

## Operation
- FSM states:
  - IDLE: wait for a request.
  - ALU_SETTLE: one wait cycle for ALU flags to settle.
  - ALU_LOAD: SRload with the settled ALU flags.
  - STROBE: a single set or reset line.
  - SAVE: flag push.
  - RESTORE: flag pop.
  - GAP: mandatory idle cycle after every ack.
- Arbitration, evaluated only in IDLE, fixed priority: rest_req > save_req > alu_req > op_req. Losers wait; their requests stay pending.
- Transitions:
  - IDLE→RESTORE | SAVE | ALU_SETTLE | STROBE, according to the winning request.
  - ALU_SETTLE→ALU_LOAD.
  - ALU_LOAD, STROBE, SAVE, RESTORE→GAP.
  - GAP→IDLE.
- ALU_LOAD: sr_load=1, sr_cin=alu_c and sr_zin=alu_z (sampled on the ALU_SETTLE→ALU_LOAD edge), alu_ack=1.
- STROBE: exactly one of sr_cset/sr_creset/sr_zset/sr_zreset per op_code, op_ack=1.
- SAVE: push {sr_c,sr_z} onto the shadow stack; no SR strobe; save_ack=1.
- RESTORE: pop the top entry; sr_load=1 with sr_cin/sr_zin=popped values; rest_ack=1.
- Overflow (save when DEPTH entries held):
  - no push, stk_err←1, save_ack still pulses.
- Underflow (restore when the stack is empty):
  - no strobe, stk_err←1, rest_ack still pulses.
- stk_err clears only on rst.
- All strobe/ack outputs are registered, zero except in their action state; sr_cin/sr_zin are 0 whenever sr_load=0.
- A request still high in IDLE after its ack is treated as a new request; requesters drop req on seeing ack.

## Timing
- Reset values:
  - FSM in IDLE.
  - All strobes, acks, sr_cin, sr_zin and stk_err are 0.
  - Shadow stack empty.
  - Reset mid-operation aborts the transaction with no strobe and no ack.
- Latency, counted from the edge that samples a req high in IDLE (edge E):
  - STROBE, SAVE and RESTORE outputs are high during cycle E..E+1; the status register captures at E+1.
  - ALU_LOAD outputs are high during E+1..E+2.
- Throughput: one transaction per 3 cycles (op/save/restore), per 4 cycles (ALU).
- Simultaneous save and restore requests: restore wins; save is served next IDLE.
- Back-to-back save then restore returns the pushed flags on the SRload edge of the restore.

## Configuration
- SR_CTRL_SHADOW_EN defined:
  - shadow stack of DEPTH entries, SAVE/RESTORE behaviour and stk_err as above.
- SR_CTRL_SHADOW_EN undefined:
  - no stack storage.
  - save_req and rest_req are still arbitrated and acked with identical timing, but produce no SR strobe.
  - stk_err is tied 0.

## Test plan
- Reset mid-STROBE: rst asserted during STROBE → all outputs 0 immediately, no op_ack, FSM in IDLE.
- op_req with op_code=0, then op_code=3 → one cycle sr_cset=1, GAP, then one cycle sr_zreset=1; each op_ack aligned with its strobe; no other strobe lines high.
- ALU path:
  - stimulus: alu_req with alu_c=1, alu_z=0.
  - response: sr_load=1, sr_cin=1, sr_zin=0 during the second cycle after grant; alu_ack in that cycle.
- Priority: alu_req, op_req and save_req raised in the same cycle → serviced in order save, alu, op, separated by GAP cycles.
- Shadow stack:
  - stimulus: with sr_c/sr_z = 1/0 then 0/1, save twice, then restore twice.
  - response: SRload data 0/1 then 1/0; stk_err stays 0.
- Stack errors (DEPTH=4):
  - five saves → stk_err=1 after the fifth, with save_ack still pulsing.
  - after a fresh reset, one restore → no sr_load, rest_ack=1, stk_err=1.
